rgb_stream_expander: RTL and testbench

//  Parametrised, pipelined pixel-format expander. Accepts packed R/G/B words (default RGB565

---
 rtl/rgb_stream_expander.sv | 147 ++++++++++++++
 tb/tb_rgb_stream_expander.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_stream_expander.sv
// Packed RGB to full-width RGB stream expander with colour-key flag.
// Two register stages, valid/ready on both sides, delivered-pixel counter.

module rgb_chan_expand #(
    parameter int W        = 5,
    parameter int OUT_BITS = 8
) (
    input  logic [W-1:0]        f,
    input  logic                rep,
    output logic [OUT_BITS-1:0] y
);

    logic [OUT_BITS-1:0] zf;
    logic [OUT_BITS-1:0] rp;

    // Output bit j (counted from the MSB) takes field bit j mod W.
    for (genvar j = 0; j < OUT_BITS; j++) begin : g_bit
        assign rp[OUT_BITS-1-j] = f[W-1-(j%W)];
        if (j < W) begin : g_fld
            assign zf[OUT_BITS-1-j] = f[W-1-j];
        end else begin : g_pad
            assign zf[OUT_BITS-1-j] = 1'b0;
        end
    end

    assign y = rep ? rp : zf;

endmodule

module rgb_stream_expander #(
    parameter int R_BITS   = 5,
    parameter int G_BITS   = 6,
    parameter int B_BITS   = 5,
    parameter int OUT_BITS = 8,
    parameter int CNT_W    = 20
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             mode_replicate,
    input  logic                             key_en,
    input  logic [R_BITS+G_BITS+B_BITS-1:0]  key_color,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [R_BITS+G_BITS+B_BITS-1:0]  in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_BITS-1:0]              R,
    output logic [OUT_BITS-1:0]              G,
    output logic [OUT_BITS-1:0]              B,
    output logic                             out_transparent,
    input  logic                             cnt_clr,
    output logic [CNT_W-1:0]                 pix_count
);

    localparam int IN_W = R_BITS + G_BITS + B_BITS;

    logic            s1_valid;
    logic [IN_W-1:0] s1_data;
    logic            s1_mode;
    logic            s1_key_en;
    logic [IN_W-1:0] s1_key_color;

    logic s2_adv;
    logic s1_adv;
    logic in_fire;
    logic out_fire;

    logic [OUT_BITS-1:0] r_exp;
    logic [OUT_BITS-1:0] g_exp;
    logic [OUT_BITS-1:0] b_exp;
    logic                key_hit;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = Reset_n && (!s1_valid || s2_adv);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Stage 1: capture the pixel together with its own mode and key settings.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            s1_mode      <= 1'b0;
            s1_key_en    <= 1'b0;
            s1_key_color <= '0;
        end else if (in_fire) begin
            s1_valid     <= 1'b1;
            s1_data      <= in_data;
            s1_mode      <= mode_replicate;
            s1_key_en    <= key_en;
            s1_key_color <= key_color;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    rgb_chan_expand #(.W(R_BITS), .OUT_BITS(OUT_BITS)) u_r (
        .f   (s1_data[IN_W-1 -: R_BITS]),
        .rep (s1_mode),
        .y   (r_exp)
    );

    rgb_chan_expand #(.W(G_BITS), .OUT_BITS(OUT_BITS)) u_g (
        .f   (s1_data[B_BITS +: G_BITS]),
        .rep (s1_mode),
        .y   (g_exp)
    );

    rgb_chan_expand #(.W(B_BITS), .OUT_BITS(OUT_BITS)) u_b (
        .f   (s1_data[B_BITS-1:0]),
        .rep (s1_mode),
        .y   (b_exp)
    );

    assign key_hit = s1_key_en && (s1_data == s1_key_color);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid       <= 1'b0;
            R               <= '0;
            G               <= '0;
            B               <= '0;
            out_transparent <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                R               <= r_exp;
                G               <= g_exp;
                B               <= b_exp;
                out_transparent <= key_hit;
            end
        end
    end

    // Clear wins over a coincident delivery.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_count <= '0;
        end else if (cnt_clr) begin
            pix_count <= '0;
        end else if (out_fire) begin
            pix_count <= pix_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rgb_stream_expander.sv
// Bench for rgb_stream_expander: vector table, latency, reset,
// random backpressure scoreboard and counter wrap/clear.

module tb_rgb_stream_expander;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        mode_replicate;
    logic        key_en;
    logic [15:0] key_color;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready4;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_valid4;
    logic        out_ready;
    logic [7:0]  R, G, B;
    logic [7:0]  R4, G4, B4;
    logic        out_transparent;
    logic        out_transparent4;
    logic        cnt_clr;
    logic [19:0] pix_count;
    logic [3:0]  pix_count4;

    always #5 Clk = ~Clk;

    rgb_stream_expander dut (
        .Clk(Clk), .Reset_n(Reset_n), .mode_replicate(mode_replicate),
        .key_en(key_en), .key_color(key_color), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .R(R), .G(G), .B(B),
        .out_transparent(out_transparent), .cnt_clr(cnt_clr),
        .pix_count(pix_count)
    );

    rgb_stream_expander #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .mode_replicate(mode_replicate),
        .key_en(key_en), .key_color(key_color), .in_valid(in_valid),
        .in_ready(in_ready4), .in_data(in_data), .out_valid(out_valid4),
        .out_ready(out_ready), .R(R4), .G(G4), .B(B4),
        .out_transparent(out_transparent4), .cnt_clr(cnt_clr),
        .pix_count(pix_count4)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [24:0] model(input logic [15:0] d,
                                          input logic m, input logic ke,
                                          input logic [15:0] kc);
        logic [9:0]  rr, bb;
        logic [11:0] gg;
        logic [7:0]  ro, go, bo;
        rr = {d[15:11], d[15:11]};
        gg = {d[10:5], d[10:5]};
        bb = {d[4:0], d[4:0]};
        ro = m ? rr[9:2] : {d[15:11], 3'b000};
        go = m ? gg[11:4] : {d[10:5], 2'b00};
        bo = m ? bb[9:2] : {d[4:0], 3'b000};
        return {ro, go, bo, ke && (d == kc)};
    endfunction

    logic [24:0] sb[$];
    logic [24:0] pend_exp;
    logic        held;
    logic [24:0] held_val;

    // Scoreboard push on accept, pop on delivery, hold check on stall.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (in_valid && in_ready) sb.push_back(pend_exp);
            if (held)
                check("stall_hold", {7'd0, out_valid, R, G, B, out_transparent},
                      {7'd0, 1'b1, held_val});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_unexpected", 32'd0, 32'd1);
                else check("sb_pixel", {7'd0, R, G, B, out_transparent},
                           {7'd0, sb.pop_front()});
            end
            held     = out_valid && !out_ready;
            held_val = {R, G, B, out_transparent};
        end else begin
            held = 1'b0;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic m, input logic ke,
                        input logic [15:0] kc, input logic [24:0] e);
        bit acc;
        bit done;
        done           = 1'b0;
        in_data        = d;
        mode_replicate = m;
        key_en         = ke;
        key_color      = kc;
        pend_exp       = e;
        in_valid       = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge Clk);
            acc = in_ready;
            tick();
            done = acc;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    typedef struct {
        logic [15:0] d;
        logic        m;
        logic        ke;
        logic [15:0] kc;
        logic [24:0] e;
    } vec_t;

    vec_t        vt[9];
    logic [15:0] rpx[64];
    logic        rm[64];
    logic        rke[64];
    logic [15:0] rkc[64];

    initial begin
        vt[0] = '{16'hFFFF, 1'b0, 1'b0, 16'h0000, {8'hF8, 8'hFC, 8'hF8, 1'b0}};
        vt[1] = '{16'hFFFF, 1'b1, 1'b0, 16'h0000, {8'hFF, 8'hFF, 8'hFF, 1'b0}};
        vt[2] = '{16'h8410, 1'b1, 1'b0, 16'h0000, {8'h84, 8'h82, 8'h84, 1'b0}};
        vt[3] = '{16'h0000, 1'b1, 1'b0, 16'h0000, {8'h00, 8'h00, 8'h00, 1'b0}};
        vt[4] = '{16'hF81F, 1'b0, 1'b1, 16'hF81F, {8'hF8, 8'h00, 8'hF8, 1'b1}};
        vt[5] = '{16'hF81E, 1'b0, 1'b1, 16'hF81F, {8'hF8, 8'h00, 8'hF0, 1'b0}};
        vt[6] = '{16'hF81E, 1'b1, 1'b1, 16'hF81E, {8'hFF, 8'h00, 8'hF7, 1'b1}};
        vt[7] = '{16'hF81F, 1'b0, 1'b0, 16'hF81F, {8'hF8, 8'h00, 8'hF8, 1'b0}};
        vt[8] = '{16'h8410, 1'b0, 1'b0, 16'h0000, {8'h80, 8'h80, 8'h80, 1'b0}};

        Reset_n        = 1'b0;
        mode_replicate = 1'b0;
        key_en         = 1'b0;
        key_color      = '0;
        in_valid       = 1'b0;
        in_data        = '0;
        out_ready      = 1'b0;
        cnt_clr        = 1'b0;
        pend_exp       = '0;
        held           = 1'b0;
        held_val       = '0;

        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_rgb", {8'd0, R, G, B}, 32'd0);
        check("rst_count", {12'd0, pix_count}, 32'd0);
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;

        // Two-stage latency of a single zero-fill pixel.
        tick();
        out_ready      = 1'b1;
        in_data        = 16'hFFFF;
        mode_replicate = 1'b0;
        key_en         = 1'b0;
        pend_exp       = {8'hF8, 8'hFC, 8'hF8, 1'b0};
        in_valid       = 1'b1;
        @(negedge Clk);
        check("t2_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge Clk);
        check("t2_lat_early", {31'd0, out_valid}, 32'd0);
        @(negedge Clk);
        check("t2_lat_valid", {31'd0, out_valid}, 32'd1);
        check("t2_rgb", {8'd0, R, G, B}, {8'd0, 8'hF8, 8'hFC, 8'hF8});
        drain();

        for (int i = 0; i < 9; i++) send(vt[i].d, vt[i].m, vt[i].ke, vt[i].kc, vt[i].e);
        drain();
        check("tbl_count", {12'd0, pix_count}, 32'd10);

        // Asynchronous reset with both stages full and stalled.
        out_ready = 1'b0;
        send(vt[1].d, vt[1].m, vt[1].ke, vt[1].kc, vt[1].e);
        send(vt[2].d, vt[2].m, vt[2].ke, vt[2].kc, vt[2].e);
        check("t1_full_ready", {31'd0, in_ready}, 32'd0);
        check("t1_full_valid", {31'd0, out_valid}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("t1_out_valid", {31'd0, out_valid}, 32'd0);
        check("t1_rgb", {7'd0, R, G, B, out_transparent}, 32'd0);
        check("t1_count", {12'd0, pix_count}, 32'd0);
        check("t1_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("t1_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Random valid/ready with per-pixel mode and key changes.
        tick();
        pulse_clr();
        for (int i = 0; i < 64; i++) begin
            rpx[i] = 16'($urandom);
            rm[i]  = 1'($urandom);
            rke[i] = 1'($urandom);
            rkc[i] = ($urandom_range(0, 1) == 0) ? rpx[i] : (rpx[i] ^ 16'h0020);
        end
        begin
            int  idx;
            int  cyc;
            bit  acc;
            idx = 0;
            cyc = 0;
            while ((idx < 64 || sb.size() != 0) && cyc < 3000) begin
                if (idx < 64 && $urandom_range(0, 3) != 0) begin
                    in_data        = rpx[idx];
                    mode_replicate = rm[idx];
                    key_en         = rke[idx];
                    key_color      = rkc[idx];
                    pend_exp       = model(rpx[idx], rm[idx], rke[idx], rkc[idx]);
                    in_valid       = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                out_ready = ($urandom_range(0, 2) != 0);
                @(negedge Clk);
                acc = in_valid && in_ready;
                tick();
                if (acc) idx++;
                cyc++;
            end
            in_valid = 1'b0;
            check("t5_all_sent", 32'(idx), 32'd64);
        end
        drain();
        check("t5_count", {12'd0, pix_count}, 32'd64);
        check("t5_count4", {28'd0, pix_count4}, 32'd0);

        // Narrow counter wraps; clear beats a coincident delivery.
        pulse_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++)
            send(16'(i * 16'h0841), 1'b0, 1'b0, 16'h0000,
                 model(16'(i * 16'h0841), 1'b0, 1'b0, 16'h0000));
        drain();
        check("t6_wrap4", {28'd0, pix_count4}, 32'd1);
        check("t6_count20", {12'd0, pix_count}, 32'd17);
        out_ready = 1'b0;
        send(16'h1234, 1'b1, 1'b0, 16'h0000, model(16'h1234, 1'b1, 1'b0, 16'h0000));
        tick();
        check("t6_pending", {31'd0, out_valid}, 32'd1);
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("t6_clr_prio", {12'd0, pix_count}, 32'd0);
        check("t6_clr_prio4", {28'd0, pix_count4}, 32'd0);
        check("t6_delivered", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
